// File: rtl/sub2_drv.sv
// rtl/sub2_drv.sv - request/response driver for the sub2 block (flattened pin interface)
//
// Purpose: accepts one request, drives its fields onto the sub2 inputs from
//   registers, waits WAIT_CYC settle cycles, captures the sub2 returns into a
//   response register and holds that response until it is consumed.
// Parameter: WAIT_CYC (1..15) settle cycles between drive and capture.
// Optional feature: macro SUB2_DRV_PARITY_EN adds output rsp_par, the XOR of
//   all 51 captured response bits.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_e, req_f, req_g, req_h      request fields
//   sig_e, sig_f_*, sig_g_*, sig_h_*  registered drives to sub2
//   sig_i, sig_j_*, sig_k_*, sig_l_*  returns from sub2
//   rsp_valid/rsp_ready             response handshake
//   rsp_i, rsp_j, rsp_k, rsp_l      repacked captured returns
//   busy                            high whenever not IDLE
//   rsp_par                         response parity (SUB2_DRV_PARITY_EN only)
module sub2_drv #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_e,
  input  logic [1:0]  req_f,
  input  logic [23:0] req_g,
  input  logic [23:0] req_h,
  output logic        sig_e,
  output logic        sig_f_0,
  output logic        sig_f_1,
  output logic [7:0]  sig_g_0,
  output logic [7:0]  sig_g_1,
  output logic [7:0]  sig_g_2,
  output logic [7:0]  sig_h_0,
  output logic [7:0]  sig_h_1,
  output logic [7:0]  sig_h_2,
  input  logic        sig_i,
  input  logic        sig_j_0,
  input  logic        sig_j_1,
  input  logic [7:0]  sig_k_0,
  input  logic [7:0]  sig_k_1,
  input  logic [7:0]  sig_k_2,
  input  logic [7:0]  sig_l_0,
  input  logic [7:0]  sig_l_1,
  input  logic [7:0]  sig_l_2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_i,
  output logic [1:0]  rsp_j,
  output logic [23:0] rsp_k,
  output logic [23:0] rsp_l,
  output logic        busy
`ifdef SUB2_DRV_PARITY_EN
  ,
  output logic        rsp_par
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        drv_e_q;
  logic [1:0]  drv_f_q;
  logic [23:0] drv_g_q;
  logic [23:0] drv_h_q;

  logic        rsp_i_q;
  logic [1:0]  rsp_j_q;
  logic [23:0] rsp_k_q;
  logic [23:0] rsp_l_q;

  logic        accept;
  logic        capture;
  logic [1:0]  ret_j;
  logic [23:0] ret_k;
  logic [23:0] ret_l;

  assign accept  = (state_q == IDLE) && req_valid;
  assign capture = (state_q == CAPTURE);

  // Repack returns with the same element ordering as the request side:
  // k is packed (element 0 in the top byte), l is unpacked (element 0 in the low byte).
  assign ret_j = {sig_j_1, sig_j_0};
  assign ret_k = {sig_k_0, sig_k_1, sig_k_2};
  assign ret_l = {sig_l_2, sig_l_1, sig_l_0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // SETTLE lasts WAIT_CYC cycles: counter runs WAIT_CYC-1 down to 0 inclusive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = DRIVE;
      end
      DRIVE: begin
        state_d = SETTLE;
        cnt_d   = CNT_LOAD;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_e_q <= 1'b0;
      drv_f_q <= 2'd0;
      drv_g_q <= 24'd0;
      drv_h_q <= 24'd0;
    end else if (accept) begin
      drv_e_q <= req_e;
      drv_f_q <= req_f;
      drv_g_q <= req_g;
      drv_h_q <= req_h;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_i_q <= 1'b0;
      rsp_j_q <= 2'd0;
      rsp_k_q <= 24'd0;
      rsp_l_q <= 24'd0;
    end else if (capture) begin
      rsp_i_q <= sig_i;
      rsp_j_q <= ret_j;
      rsp_k_q <= ret_k;
      rsp_l_q <= ret_l;
    end
  end

`ifdef SUB2_DRV_PARITY_EN
  logic rsp_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_par_q <= 1'b0;
    end else if (capture) begin
      rsp_par_q <= ^{sig_i, ret_j, ret_k, ret_l};
    end
  end

  assign rsp_par = rsp_par_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);

  assign sig_e   = drv_e_q;
  assign sig_f_0 = drv_f_q[0];
  assign sig_f_1 = drv_f_q[1];
  assign sig_g_0 = drv_g_q[23:16];
  assign sig_g_1 = drv_g_q[15:8];
  assign sig_g_2 = drv_g_q[7:0];
  assign sig_h_0 = drv_h_q[7:0];
  assign sig_h_1 = drv_h_q[15:8];
  assign sig_h_2 = drv_h_q[23:16];

  assign rsp_i = rsp_i_q;
  assign rsp_j = rsp_j_q;
  assign rsp_k = rsp_k_q;
  assign rsp_l = rsp_l_q;

endmodule
